trap_ctrl: RTL and testbench

// Machine-mode trap sequencer next to the CSR file. It takes synchronous exception requests,

---
 rtl/trap_pkg.sv | 23 ++
 rtl/trap_ctrl_if.sv | 44 ++++
 rtl/irq_sync.sv | 25 ++
 rtl/trap_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_trap_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_pkg.sv
// Shared state encoding, interrupt cause codes and CSR bit positions
// for the machine-mode trap sequencer.
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ENTER    = 2'd1,
        RETURN   = 2'd2,
        REDIRECT = 2'd3
    } trap_state_e;

    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam int MIP_MSIP = 3;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MEIP = 11;

endpackage

// File: rtl/trap_ctrl_if.sv
// Core/CSR-side signal bundle of the trap sequencer; master is the core and
// CSR file, slave is trap_ctrl.
interface trap_ctrl_if #(
    parameter int XLEN = 32
);
    logic            exc_req;
    logic [3:0]      exc_code;
    logic [XLEN-1:0] exc_pc;
    logic [XLEN-1:0] exc_tval;
    logic            mret_req;
    logic            insn_done;
    logic [XLEN-1:0] next_pc;
    logic            ext_irq;
    logic            sw_irq;
    logic            time_compare;
    logic [XLEN-1:0] mstatus;
    logic [XLEN-1:0] mie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mip;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mbadaddr;
    logic [XLEN-1:0] mepc;
    logic            mstatus_we;
    logic [XLEN-1:0] mstatus_wd;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ack;
    logic            busy;

    modport master (
        output exc_req, exc_code, exc_pc, exc_tval, mret_req, insn_done, next_pc,
               ext_irq, sw_irq, time_compare, mstatus, mie, mtvec, redirect_ack,
        input  mip, mcause, mbadaddr, mepc, mstatus_we, mstatus_wd,
               redirect, redirect_pc, busy
    );

    modport slave (
        input  exc_req, exc_code, exc_pc, exc_tval, mret_req, insn_done, next_pc,
               ext_irq, sw_irq, time_compare, mstatus, mie, mtvec, redirect_ack,
        output mip, mcause, mbadaddr, mepc, mstatus_we, mstatus_wd,
               redirect, redirect_pc, busy
    );

endinterface

// File: rtl/irq_sync.sv
// Multi-flop synchronizer bringing an asynchronous interrupt line into the
// clk domain.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chain_r <= {STAGES{1'b0}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions, interrupts and MRET at
// instruction boundaries and drives the CSR trap state plus a fetch redirect.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int SYNC_STAGES = 2,
    parameter int VECTOR_EN   = 1
) (
    input logic        clk,
    input logic        resetn,
    trap_ctrl_if.slave bus
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] XZERO      = {XLEN{1'b0}};

    function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] cur);
        logic [XLEN-1:0] nxt;
        nxt               = cur;
        nxt[MSTATUS_MPIE] = cur[MSTATUS_MIE];
        nxt[MSTATUS_MIE]  = 1'b0;
        return nxt;
    endfunction

    function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] cur);
        logic [XLEN-1:0] nxt;
        nxt               = cur;
        nxt[MSTATUS_MIE]  = cur[MSTATUS_MPIE];
        nxt[MSTATUS_MPIE] = 1'b1;
        return nxt;
    endfunction

    trap_state_e     state_r;
    logic            ext_sync_s;
    logic            msip_r;
    logic            mtip_r;
    logic [XLEN-1:0] mip_s;
    logic [XLEN-1:0] irq_en_s;
    logic            irq_pend_s;
    logic [3:0]      irq_code_s;
    logic [XLEN-1:0] vec_base_s;
    logic [XLEN-1:0] trap_target_s;
    logic [XLEN-1:0] mcause_r;
    logic [XLEN-1:0] mbadaddr_r;
    logic [XLEN-1:0] mepc_r;
    logic [XLEN-1:0] mstatus_wd_r;
    logic [XLEN-1:0] redirect_pc_r;
    logic            mstatus_we_r;
    logic            redirect_r;
    logic            busy_r;

    irq_sync #(
        .STAGES(SYNC_STAGES)
    ) u_ext_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (bus.ext_irq),
        .q      (ext_sync_s)
    );

    // Software and timer lines are already synchronous; register them once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            msip_r <= 1'b0;
            mtip_r <= 1'b0;
        end else begin
            msip_r <= bus.sw_irq;
            mtip_r <= bus.time_compare;
        end
    end

    // Assemble the pending-interrupt word from the registered sources.
    always_comb begin
        mip_s           = XZERO;
        mip_s[MIP_MEIP] = ext_sync_s;
        mip_s[MIP_MTIP] = mtip_r;
        mip_s[MIP_MSIP] = msip_r;
    end

    // Pending/enabled interrupt detection and fixed MEI > MSI > MTI priority.
    always_comb begin
        irq_en_s   = bus.mie & mip_s;
        irq_pend_s = bus.mstatus[MSTATUS_MIE] & (|irq_en_s);
        if (irq_en_s[MIP_MEIP]) begin
            irq_code_s = CAUSE_MEI;
        end else if (irq_en_s[MIP_MSIP]) begin
            irq_code_s = CAUSE_MSI;
        end else begin
            irq_code_s = CAUSE_MTI;
        end
    end

    // Trap target; only interrupts in mode 1 are vectored, modes 2/3 act as direct.
    always_comb begin
        vec_base_s = bus.mtvec & ALIGN_MASK;
        if ((VECTOR_EN != 0) && mcause_r[XLEN-1] && (bus.mtvec[1:0] == 2'b01)) begin
            trap_target_s = vec_base_s + {{(XLEN-6){1'b0}}, mcause_r[3:0], 2'b00};
        end else begin
            trap_target_s = vec_base_s;
        end
    end

    // Trap sequencer FSM with all CSR and fetch outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= IDLE;
            mcause_r      <= XZERO;
            mbadaddr_r    <= XZERO;
            mepc_r        <= XZERO;
            mstatus_wd_r  <= XZERO;
            redirect_pc_r <= XZERO;
            mstatus_we_r  <= 1'b0;
            redirect_r    <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            mstatus_we_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.exc_req) begin
                        state_r      <= ENTER;
                        busy_r       <= 1'b1;
                        mcause_r     <= {1'b0, {(XLEN-5){1'b0}}, bus.exc_code};
                        mbadaddr_r   <= bus.exc_tval;
                        mepc_r       <= bus.exc_pc & ALIGN_MASK;
                        mstatus_we_r <= 1'b1;
                        mstatus_wd_r <= mstatus_on_trap(bus.mstatus);
                    end else if (irq_pend_s && bus.insn_done) begin
                        state_r      <= ENTER;
                        busy_r       <= 1'b1;
                        mcause_r     <= {1'b1, {(XLEN-5){1'b0}}, irq_code_s};
                        mbadaddr_r   <= XZERO;
                        mepc_r       <= bus.next_pc & ALIGN_MASK;
                        mstatus_we_r <= 1'b1;
                        mstatus_wd_r <= mstatus_on_trap(bus.mstatus);
                    end else if (bus.mret_req) begin
                        state_r      <= RETURN;
                        busy_r       <= 1'b1;
                        mstatus_we_r <= 1'b1;
                        mstatus_wd_r <= mstatus_on_mret(bus.mstatus);
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ENTER: begin
                    redirect_pc_r <= trap_target_s;
                    redirect_r    <= 1'b1;
                    state_r       <= REDIRECT;
                end
                RETURN: begin
                    redirect_pc_r <= mepc_r;
                    redirect_r    <= 1'b1;
                    state_r       <= REDIRECT;
                end
                REDIRECT: begin
                    if (bus.redirect_ack) begin
                        redirect_r <= 1'b0;
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        state_r <= REDIRECT;
                    end
                end
                default: begin
                    redirect_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign bus.mip         = mip_s;
    assign bus.mcause      = mcause_r;
    assign bus.mbadaddr    = mbadaddr_r;
    assign bus.mepc        = mepc_r;
    assign bus.mstatus_we  = mstatus_we_r;
    assign bus.mstatus_wd  = mstatus_wd_r;
    assign bus.redirect    = redirect_r;
    assign bus.redirect_pc = redirect_pc_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: expected trap records go into a queue
// when a request is driven and are compared against what the DUT produces.
module tb_trap_ctrl;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    trap_ctrl_if #(.XLEN(32)) bus ();

    trap_ctrl #(
        .XLEN        (32),
        .SYNC_STAGES (2),
        .VECTOR_EN   (1)
    ) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct packed {
        logic [31:0] cause;
        logic [31:0] bad;
        logic [31:0] epc;
        logic [31:0] wd;
        logic [31:0] rpc;
    } trap_rec_t;

    trap_rec_t   exp_q[$];
    logic [31:0] m_cause = 32'h0;
    logic [31:0] m_bad   = 32'h0;
    logic [31:0] m_epc   = 32'h0;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    task automatic clear_inputs();
        bus.exc_req = 1'b0;      bus.exc_code = 4'd0;
        bus.exc_pc = 32'h0;      bus.exc_tval = 32'h0;
        bus.mret_req = 1'b0;     bus.insn_done = 1'b0;
        bus.next_pc = 32'h0;     bus.ext_irq = 1'b0;
        bus.sw_irq = 1'b0;       bus.time_compare = 1'b0;
        bus.mstatus = 32'h0;     bus.mie = 32'h0;
        bus.mtvec = 32'h0;       bus.redirect_ack = 1'b0;
    endtask

    // Model of the CSR trap state: a trap overwrites it, MRET keeps it.
    task automatic expect_trap(input logic [31:0] cause, bad, epc, wd, rpc);
        exp_q.push_back({cause, bad, epc, wd, rpc});
        m_cause = cause;
        m_bad   = bad;
        m_epc   = epc;
    endtask

    task automatic expect_mret(input logic [31:0] wd, rpc);
        exp_q.push_back({m_cause, m_bad, m_epc, wd, rpc});
    endtask

    // Waits for the mstatus pulse and the redirect; insn_done is a one-cycle pulse.
    task automatic observe(output trap_rec_t obs, output int cyc, output bit ok);
        obs = '0;
        cyc = 0;
        ok  = 1'b0;
        for (int i = 1; i <= 20 && !ok; i++) begin
            @(negedge clk);
            bus.insn_done = 1'b0;
            if (bus.mstatus_we) begin
                obs.cause = bus.mcause;
                obs.bad   = bus.mbadaddr;
                obs.epc   = bus.mepc;
                obs.wd    = bus.mstatus_wd;
            end
            if (bus.redirect) begin
                obs.rpc = bus.redirect_pc;
                cyc     = i;
                ok      = 1'b1;
            end
        end
    endtask

    task automatic ack();
        bus.redirect_ack = 1'b1;
        bus.exc_req      = 1'b0;
        bus.mret_req     = 1'b0;
        @(negedge clk);
        bus.redirect_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got [7];
        string       nm  [7];
        clear_inputs();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        got = '{bus.mip, bus.mcause, bus.mbadaddr, bus.mepc, bus.mstatus_wd, bus.redirect_pc,
                {29'h0, bus.mstatus_we, bus.redirect, bus.busy}};
        nm  = '{"rst_mip", "rst_mcause", "rst_mbadaddr", "rst_mepc", "rst_wd", "rst_rpc", "rst_ctl"};
        for (int i = 0; i < 7; i++) begin
            vec_cnt++;
            if (got[i] !== 32'h0) begin
                err_cnt++;
                $display("FAIL %s: got %h want 00000000", nm[i], got[i]);
            end
        end
        resetn = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (bus.busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_release_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_exception();
        trap_rec_t obs; int cyc; bit ok;
        bus.mtvec = 32'h200; bus.mstatus = 32'h8;
        bus.exc_req = 1'b1; bus.exc_code = 4'd2; bus.exc_pc = 32'h104; bus.exc_tval = 32'hDEAD;
        expect_trap(32'h2, 32'hDEAD, 32'h104, 32'h80, 32'h200);
        observe(obs, cyc, ok);
        vec_cnt++;
        if (!ok || obs !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL exc_trap: got %h want %h seen=%b", obs, exp_q[0], ok);
        end
        void'(exp_q.pop_front());
        vec_cnt++;
        if (cyc !== 2 || bus.busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL exc_latency: got cyc=%0d busy=%b want cyc=2 busy=1", cyc, bus.busy);
        end
        ack();
        vec_cnt++;
        if (bus.redirect !== 1'b0 || bus.busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL exc_ack: got redirect=%b busy=%b want 0 0", bus.redirect, bus.busy);
        end
    endtask

    task automatic test_vectored_timer();
        trap_rec_t obs; int cyc; bit ok;
        bus.mtvec = 32'h201; bus.mie = 32'h80; bus.mstatus = 32'h8; bus.time_compare = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (bus.mip !== 32'h80) begin
            err_cnt++;
            $display("FAIL mip_timer: got %h want 00000080", bus.mip);
        end
        bus.insn_done = 1'b1; bus.next_pc = 32'h40;
        expect_trap(32'h80000007, 32'h0, 32'h40, 32'h80, 32'h21C);
        observe(obs, cyc, ok);
        vec_cnt++;
        if (!ok || obs !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL timer_trap: got %h want %h seen=%b", obs, exp_q[0], ok);
        end
        void'(exp_q.pop_front());
        bus.time_compare = 1'b0;
        ack();
    endtask

    task automatic test_masking();
        trap_rec_t obs; int cyc; bit ok;
        bus.mstatus = 32'h0; bus.mie = 32'h800; bus.mtvec = 32'h301; bus.ext_irq = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (bus.mip[11] !== 1'b0) begin
            err_cnt++;
            $display("FAIL mip_sync1: got %b want 0", bus.mip[11]);
        end
        @(negedge clk);
        vec_cnt++;
        if (bus.mip[11] !== 1'b1) begin
            err_cnt++;
            $display("FAIL mip_sync2: got %b want 1", bus.mip[11]);
        end
        bus.insn_done = 1'b1; bus.next_pc = 32'h80;
        repeat (4) @(negedge clk);
        vec_cnt++;
        if (bus.redirect !== 1'b0 || bus.busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL masked_irq: got redirect=%b busy=%b want 0 0", bus.redirect, bus.busy);
        end
        bus.mstatus = 32'h8;
        expect_trap(32'h8000000B, 32'h0, 32'h80, 32'h80, 32'h32C);
        observe(obs, cyc, ok);
        vec_cnt++;
        if (!ok || obs !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL unmasked_irq: got %h want %h seen=%b", obs, exp_q[0], ok);
        end
        void'(exp_q.pop_front());
        bus.ext_irq = 1'b0;
        ack();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_priority();
        trap_rec_t obs; int cyc; bit ok;
        bus.mtvec = 32'h200; bus.mie = 32'h888; bus.mstatus = 32'h8;
        bus.ext_irq = 1'b1; bus.sw_irq = 1'b1; bus.time_compare = 1'b1;
        repeat (3) @(negedge clk);
        bus.insn_done = 1'b1; bus.next_pc = 32'h50;
        expect_trap(32'h8000000B, 32'h0, 32'h50, 32'h80, 32'h200);
        observe(obs, cyc, ok);
        vec_cnt++;
        if (!ok || obs !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL prio_mei: got %h want %h seen=%b", obs, exp_q[0], ok);
        end
        void'(exp_q.pop_front());
        bus.ext_irq = 1'b0;
        ack();
        repeat (3) @(negedge clk);
        bus.insn_done = 1'b1; bus.next_pc = 32'h54;
        expect_trap(32'h80000003, 32'h0, 32'h54, 32'h80, 32'h200);
        observe(obs, cyc, ok);
        vec_cnt++;
        if (!ok || obs !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL prio_msi: got %h want %h seen=%b", obs, exp_q[0], ok);
        end
        void'(exp_q.pop_front());
        ack();
        bus.exc_req = 1'b1; bus.exc_code = 4'd5; bus.exc_pc = 32'h60; bus.exc_tval = 32'h1234;
        bus.mret_req = 1'b1; bus.insn_done = 1'b1; bus.next_pc = 32'h64;
        expect_trap(32'h5, 32'h1234, 32'h60, 32'h80, 32'h200);
        observe(obs, cyc, ok);
        vec_cnt++;
        if (!ok || obs !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL prio_exc: got %h want %h seen=%b", obs, exp_q[0], ok);
        end
        void'(exp_q.pop_front());
        bus.sw_irq = 1'b0; bus.time_compare = 1'b0;
        ack();
        @(negedge clk);
        vec_cnt++;
        if (bus.busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL prio_no_mret: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_mret();
        trap_rec_t obs; int cyc; bit ok;
        bus.mtvec = 32'h200; bus.mstatus = 32'h88;
        bus.exc_req = 1'b1; bus.exc_code = 4'd11; bus.exc_pc = 32'h300; bus.exc_tval = 32'h0;
        expect_trap(32'hB, 32'h0, 32'h300, 32'h80, 32'h200);
        observe(obs, cyc, ok);
        vec_cnt++;
        if (!ok || obs !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL mret_setup: got %h want %h seen=%b", obs, exp_q[0], ok);
        end
        void'(exp_q.pop_front());
        ack();
        bus.mstatus = 32'h80; bus.mret_req = 1'b1;
        expect_mret(32'h88, 32'h300);
        observe(obs, cyc, ok);
        vec_cnt++;
        if (!ok || obs !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL mret_mpie1: got %h want %h seen=%b", obs, exp_q[0], ok);
        end
        void'(exp_q.pop_front());
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (bus.redirect !== 1'b1 || bus.busy !== 1'b1) begin
                err_cnt++;
                $display("FAIL mret_hold%0d: got redirect=%b busy=%b want 1 1", i, bus.redirect, bus.busy);
            end
        end
        ack();
        bus.mstatus = 32'h8; bus.mret_req = 1'b1;
        expect_mret(32'h80, 32'h300);
        observe(obs, cyc, ok);
        vec_cnt++;
        if (!ok || obs !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL mret_mpie0: got %h want %h seen=%b", obs, exp_q[0], ok);
        end
        void'(exp_q.pop_front());
        ack();
    endtask

    task automatic test_back_to_back();
        trap_rec_t obs; int cyc; bit ok;
        bus.mtvec = 32'h203; bus.mstatus = 32'h8;
        bus.exc_req = 1'b1; bus.exc_code = 4'd1; bus.exc_pc = 32'h200; bus.exc_tval = 32'h11;
        expect_trap(32'h1, 32'h11, 32'h200, 32'h80, 32'h200);
        observe(obs, cyc, ok);
        vec_cnt++;
        if (!ok || obs !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL b2b_first: got %h want %h seen=%b", obs, exp_q[0], ok);
        end
        void'(exp_q.pop_front());
        ack();
        bus.exc_req = 1'b1; bus.exc_code = 4'd13; bus.exc_pc = 32'h10B; bus.exc_tval = 32'h77;
        expect_trap(32'hD, 32'h77, 32'h108, 32'h80, 32'h200);
        observe(obs, cyc, ok);
        vec_cnt++;
        if (!ok || obs !== exp_q[0] || cyc !== 2) begin
            err_cnt++;
            $display("FAIL b2b_second: got %h cyc=%0d want %h cyc=2", obs, cyc, exp_q[0]);
        end
        void'(exp_q.pop_front());
        ack();
    endtask

    task automatic test_async_reset();
        trap_rec_t obs; int cyc; bit ok;
        bus.mtvec = 32'h200; bus.mstatus = 32'h8;
        bus.exc_req = 1'b1; bus.exc_code = 4'd7; bus.exc_pc = 32'h400; bus.exc_tval = 32'h5;
        expect_trap(32'h7, 32'h5, 32'h400, 32'h80, 32'h200);
        observe(obs, cyc, ok);
        vec_cnt++;
        if (!ok || obs !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL arst_setup: got %h want %h seen=%b", obs, exp_q[0], ok);
        end
        void'(exp_q.pop_front());
        #2;
        resetn = 1'b0;
        #1;
        vec_cnt++;
        if (bus.redirect !== 1'b0 || bus.busy !== 1'b0 || bus.mstatus_we !== 1'b0 || bus.mcause !== 32'h0) begin
            err_cnt++;
            $display("FAIL arst_immediate: got redirect=%b busy=%b we=%b mcause=%h want 0 0 0 0",
                     bus.redirect, bus.busy, bus.mstatus_we, bus.mcause);
        end
        bus.exc_req = 1'b0;
        m_cause = 32'h0; m_bad = 32'h0; m_epc = 32'h0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (bus.redirect !== 1'b0 || bus.busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL arst_release: got redirect=%b busy=%b want 0 0", bus.redirect, bus.busy);
        end
        bus.exc_req = 1'b1; bus.exc_code = 4'd3; bus.exc_pc = 32'h500; bus.exc_tval = 32'h9;
        expect_trap(32'h3, 32'h9, 32'h500, 32'h80, 32'h200);
        observe(obs, cyc, ok);
        vec_cnt++;
        if (!ok || obs !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL arst_recover: got %h want %h seen=%b", obs, exp_q[0], ok);
        end
        void'(exp_q.pop_front());
        ack();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_exception();
        test_vectored_timer();
        test_masking();
        test_priority();
        test_mret();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
